// File: rtl/tl_probe_sequencer.sv
// rtl/tl_probe_sequencer.sv - sequences L2 coherence probes onto the B channel and collects C-channel acks
module tl_probe_sequencer #(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = 64,
  parameter int SOURCE_W  = 4,
  parameter int CID_W     = $clog2(N_CLIENTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // probe command from the L2 controller
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [N_CLIENTS-1:0] req_targets_i,
  input  logic [2:0]           req_param_i,
  input  logic [3:0]           req_size_i,
  input  logic [SOURCE_W-1:0]  req_source_i,
  input  logic [ADDR_W-1:0]    req_address_i,
  // directed B channel towards the socket demux
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [2:0]           b_opcode_o,
  output logic [2:0]           b_param_o,
  output logic [3:0]           b_size_o,
  output logic [SOURCE_W-1:0]  b_source_o,
  output logic [ADDR_W-1:0]    b_address_o,
  output logic [7:0]           b_mask_o,
  output logic [CID_W-1:0]     b_dest_o,
  // ProbeAck / ProbeAckData observations from C
  input  logic                 ack_valid_i,
  input  logic [CID_W-1:0]     ack_client_i,
  input  logic                 ack_data_i,
  // completion back to the L2 controller
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic                 done_dirty_o,
  output logic                 busy_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [N_CLIENTS-1:0] ONE_HOT0 = {{(N_CLIENTS-1){1'b0}}, 1'b1};

  state_t               state;
  logic [N_CLIENTS-1:0] pend_issue;   // targets whose B beat has not been sent yet
  logic [N_CLIENTS-1:0] issued;       // beats sent whose ack is still outstanding
  logic                 dirty;

  logic                 b_fire;
  logic                 ack_state;
  logic                 ack_ok;
  logic [N_CLIENTS-1:0] fire_bit;
  logic [N_CLIENTS-1:0] ack_bit;
  logic [N_CLIENTS-1:0] pend_n;
  logic [N_CLIENTS-1:0] issued_n;
  logic                 dirty_n;

  // Index of the lowest set bit; zero when the mask is empty.
  function automatic logic [CID_W-1:0] lowest_idx(input logic [N_CLIENTS-1:0] m);
    lowest_idx = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = CID_W'(i);
    end
  endfunction

  assign b_opcode_o = 3'd6;
  assign b_mask_o   = 8'hFF;

  // Next-cycle masks: a beat firing and an ack landing in the same cycle are both applied.
  // The ack is judged against the pre-update issued mask, so acking a beat that fires
  // this very cycle is treated as unexpected.
  always_comb begin
    b_fire    = b_valid_o && b_ready_i;
    ack_state = (state == ST_ISSUE) || (state == ST_WAIT);
    ack_ok    = ack_valid_i && ack_state && issued[ack_client_i];
    fire_bit  = b_fire ? (ONE_HOT0 << b_dest_o) : '0;
    ack_bit   = ack_ok ? (ONE_HOT0 << ack_client_i) : '0;
    pend_n    = pend_issue & ~fire_bit;
    issued_n  = (issued | fire_bit) & ~ack_bit;
    dirty_n   = dirty | (ack_ok & ack_data_i);
  end

  // Sequencer FSM with registered handshake, B-channel and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pend_issue   <= '0;
      issued       <= '0;
      dirty        <= 1'b0;
      req_ready_o  <= 1'b1;
      b_valid_o    <= 1'b0;
      b_dest_o     <= '0;
      b_param_o    <= '0;
      b_size_o     <= '0;
      b_source_o   <= '0;
      b_address_o  <= '0;
      done_valid_o <= 1'b0;
      done_dirty_o <= 1'b0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      err_o      <= ack_valid_i && !ack_ok;
      pend_issue <= pend_n;
      issued     <= issued_n;
      dirty      <= dirty_n;

      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            b_param_o   <= req_param_i;
            b_size_o    <= req_size_i;
            b_source_o  <= req_source_i;
            b_address_o <= req_address_i;
            pend_issue  <= req_targets_i;
            issued      <= '0;
            dirty       <= 1'b0;
            b_dest_o    <= lowest_idx(req_targets_i);
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (req_targets_i != '0) begin
              state     <= ST_ISSUE;
              b_valid_o <= 1'b1;
            end else begin
              state        <= ST_DONE;
              done_valid_o <= 1'b1;
              done_dirty_o <= 1'b0;
            end
          end
        end

        ST_ISSUE: begin
          if (b_fire) begin
            b_dest_o <= lowest_idx(pend_n);
            if (pend_n == '0) begin
              b_valid_o <= 1'b0;
              if (issued_n == '0) begin
                state        <= ST_DONE;
                done_valid_o <= 1'b1;
                done_dirty_o <= dirty_n;
              end else begin
                state <= ST_WAIT;
              end
            end
          end
        end

        ST_WAIT: begin
          if (issued_n == '0) begin
            state        <= ST_DONE;
            done_valid_o <= 1'b1;
            done_dirty_o <= dirty_n;
          end
        end

        ST_DONE: begin
          if (done_ready_i) begin
            state        <= ST_IDLE;
            done_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_probe_sequencer.sv
// tb/tb_tl_probe_sequencer.sv - randomized self-checking bench for tl_probe_sequencer
module tb_tl_probe_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_targets = '0;
  logic [2:0]  req_param = '0;
  logic [3:0]  req_size = '0;
  logic [3:0]  req_source = '0;
  logic [63:0] req_address = '0;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [2:0]  b_opcode;
  logic [2:0]  b_param;
  logic [3:0]  b_size;
  logic [3:0]  b_source;
  logic [63:0] b_address;
  logic [7:0]  b_mask;
  logic [1:0]  b_dest;
  logic        ack_valid = 1'b0;
  logic [1:0]  ack_client = '0;
  logic        ack_data = 1'b0;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic        done_dirty;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;

  tl_probe_sequencer #(.N_CLIENTS(N), .ADDR_W(64), .SOURCE_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_targets_i(req_targets),
    .req_param_i(req_param), .req_size_i(req_size), .req_source_i(req_source),
    .req_address_i(req_address),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_opcode_o(b_opcode), .b_param_o(b_param),
    .b_size_o(b_size), .b_source_o(b_source), .b_address_o(b_address), .b_mask_o(b_mask),
    .b_dest_o(b_dest),
    .ack_valid_i(ack_valid), .ack_client_i(ack_client), .ack_data_i(ack_data),
    .done_valid_o(done_valid), .done_ready_i(done_ready), .done_dirty_o(done_dirty),
    .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one probe command and play the socket side against a set-based model:
  // beats must appear in ascending client order, acks are legal only for clients
  // already probed and not yet acked, dirty is the OR of legal ProbeAckData acks.
  task automatic run_probe(input logic [3:0] tg, input int ready_pct, input int ack_pct,
                           input int bad_pct, input int hold, input logic [63:0] addr,
                           input logic [2:0] prm);
    int   q[$];
    int   outs[$];
    bit   sent[N];
    bit   acked[N];
    bit   dirty_exp;
    bit   err_exp;
    bit   complete;
    bit   fired;
    int   budget;
    int   since;
    int   c;
    bit   d;
    logic [3:0] sz;
    logic [3:0] src;

    sz  = 4'($urandom_range(0, 15));
    src = 4'($urandom_range(0, 15));
    for (int i = 0; i < N; i++) begin
      sent[i]  = 1'b0;
      acked[i] = 1'b0;
      if (tg[i]) q.push_back(i);
    end
    dirty_exp = 1'b0;
    err_exp   = 1'b0;
    budget    = 0;
    since     = 0;

    check("idle_req_ready", 64'(req_ready), 64'(1));
    req_valid   = 1'b1;
    req_targets = tg;
    req_param   = prm;
    req_size    = sz;
    req_source  = src;
    req_address = addr;
    tick();
    req_valid   = 1'b0;
    req_targets = 4'($urandom_range(0, 15));
    req_address = {$urandom, $urandom};

    while (1) begin
      check("err", 64'(err), 64'(err_exp));
      err_exp   = 1'b0;
      ack_valid = 1'b0;
      b_ready   = 1'b0;
      complete  = (q.size() == 0);
      for (int i = 0; i < N; i++) if (sent[i] && !acked[i]) complete = 1'b0;
      if (done_valid) begin
        check("done_early", 64'(complete), 64'(1));
        break;
      end
      if (complete) since++;
      if (since > 3) begin
        check("done_timeout", 64'(done_valid), 64'(1));
        break;
      end
      budget++;
      if (budget > 400) begin
        check("probe_timeout", 64'(done_valid), 64'(1));
        break;
      end
      check("busy", 64'(busy), 64'(1));
      check("req_ready_busy", 64'(req_ready), 64'(0));
      check("b_valid", 64'(b_valid), 64'(q.size() != 0));
      if (b_valid && q.size() != 0) begin
        check("b_dest", 64'(b_dest), 64'(q[0]));
        check("b_opcode", 64'(b_opcode), 64'(6));
        check("b_mask", 64'(b_mask), 64'(8'hFF));
        check("b_param", 64'(b_param), 64'(prm));
        check("b_size", 64'(b_size), 64'(sz));
        check("b_source", 64'(b_source), 64'(src));
        check("b_address", b_address, addr);
      end
      b_ready = (int'($urandom_range(0, 99)) < ready_pct);
      if (int'($urandom_range(0, 99)) < ack_pct) begin
        c = -1;
        if (int'($urandom_range(0, 99)) < bad_pct) begin
          c = int'($urandom_range(0, N - 1));
        end else begin
          outs.delete();
          for (int i = 0; i < N; i++) if (sent[i] && !acked[i]) outs.push_back(i);
          if (outs.size() != 0) c = outs[$urandom_range(0, outs.size() - 1)];
        end
        if (c >= 0) begin
          d          = 1'($urandom_range(0, 1));
          ack_valid  = 1'b1;
          ack_client = 2'(c);
          ack_data   = d;
          if (sent[c] && !acked[c]) begin
            acked[c]  = 1'b1;
            dirty_exp = dirty_exp | d;
          end else begin
            err_exp = 1'b1;
          end
        end
      end
      fired = b_valid && b_ready && (q.size() != 0);
      if (fired) begin
        sent[q[0]] = 1'b1;
        void'(q.pop_front());
      end
      tick();
    end

    ack_valid = 1'b0;
    b_ready   = 1'b0;
    check("done_dirty", 64'(done_dirty), 64'(dirty_exp));
    for (int h = 0; h < hold; h++) begin
      tick();
      check("done_hold", 64'(done_valid), 64'(1));
      check("req_ready_hold", 64'(req_ready), 64'(0));
      check("err_hold", 64'(err), 64'(0));
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("idle_req_ready_after", 64'(req_ready), 64'(1));
    check("done_clear", 64'(done_valid), 64'(0));
    check("busy_clear", 64'(busy), 64'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_b_valid", 64'(b_valid), 64'(0));
    check("rst_done_valid", 64'(done_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_b_dest", 64'(b_dest), 64'(0));
    check("rst_b_address", b_address, 64'(0));

    // single target, no backpressure
    run_probe(4'b0100, 100, 100, 0, 0, 64'h1000, 3'd2);
    // all targets with backpressure
    run_probe(4'b1111, 40, 60, 0, 2, 64'h2040, 3'd1);
    // empty target mask, completion held for 5 cycles
    run_probe(4'b0000, 100, 0, 0, 5, 64'h3000, 3'd0);
    // stray and duplicate acks
    run_probe(4'b0011, 100, 80, 60, 1, 64'h4000, 3'd2);

    // ack of client 0 in the same cycle as the B beat to client 1
    req_valid = 1'b1; req_targets = 4'b0011; req_address = 64'h5000; req_param = 3'd2;
    tick();
    req_valid = 1'b0;
    b_ready   = 1'b1;
    check("sim_dest0", 64'(b_dest), 64'(0));
    tick();
    check("sim_dest1", 64'(b_dest), 64'(1));
    check("sim_valid1", 64'(b_valid), 64'(1));
    ack_valid = 1'b1; ack_client = 2'd0; ack_data = 1'b0;
    tick();
    b_ready = 1'b0;
    check("sim_err", 64'(err), 64'(0));
    check("sim_b_idle", 64'(b_valid), 64'(0));
    check("sim_not_done", 64'(done_valid), 64'(0));
    ack_client = 2'd1;
    tick();
    ack_valid = 1'b0;
    check("sim_err2", 64'(err), 64'(0));
    for (int w = 0; w < 3 && !done_valid; w++) tick();
    check("sim_done", 64'(done_valid), 64'(1));
    check("sim_dirty", 64'(done_dirty), 64'(0));
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;

    // ack while idle is unexpected
    ack_valid = 1'b1; ack_client = 2'd1;
    tick();
    ack_valid = 1'b0;
    check("idle_ack_err", 64'(err), 64'(1));
    tick();
    check("idle_ack_err_pulse", 64'(err), 64'(0));

    // reset in the middle of issuing
    req_valid = 1'b1; req_targets = 4'b1111; b_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_b_valid", 64'(b_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_b_valid", 64'(b_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_req_ready", 64'(req_ready), 64'(1));
    check("mid_rst_done", 64'(done_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_probe(4'b1010, 70, 70, 10, 1, 64'h6000, 3'd1);

    for (int r = 0; r < 40; r++) begin
      run_probe(4'($urandom_range(0, 15)), int'($urandom_range(30, 100)),
                int'($urandom_range(20, 100)), int'($urandom_range(0, 30)),
                int'($urandom_range(0, 3)), {$urandom, $urandom}, 3'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_probe_sequencer.md
Name: tl_probe_sequencer

Overview:
Sequences coherence probes from the L2 onto the directed B channel of the N-client TileLink socket. It accepts one probe command carrying a client target mask and issues one Probe beat per target, lowest index first, driving the per-beat destination client ID. It then tracks ProbeAck/ProbeAckData returns from the C channel and reports completion, plus whether any dirty data returned, to the L2 controller.

Parameters:
N_CLIENTS, 4, number of clients on the socket; power of two, ≥2
ADDR_W, 64, address width
SOURCE_W, 4, L2 source ID width on channel B
CID_W, $clog2(N_CLIENTS), client ID width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  probe command valid
req_ready_o  out  1  command accepted when both high
req_targets_i  in  N_CLIENTS  clients to probe, bit i = client i
req_param_i  in  3  cap param (toN=2, toB=1, toT=0)
req_size_i  in  4  log2 bytes
req_source_i  in  SOURCE_W  L2 source ID placed on B
req_address_i  in  ADDR_W  line address
b_valid_o  out  1  B beat valid
b_ready_i  in  1  B beat accepted (socket demux ready)
b_opcode_o  out  3  fixed 3'd6 (ProbeBlock)
b_param_o  out  3  latched req_param_i
b_size_o  out  4  latched req_size_i
b_source_o  out  SOURCE_W  latched req_source_i
b_address_o  out  ADDR_W  latched req_address_i
b_mask_o  out  8  fixed 8'hFF
b_dest_o  out  CID_W  target client of current beat
ack_valid_i  in  1  ProbeAck/ProbeAckData first beat observed on C
ack_client_i  in  CID_W  client ID (upper source bits from C)
ack_data_i  in  1  1 = ProbeAckData
done_valid_o  out  1  all targets acked
done_ready_i  in  1  completion consumed
done_dirty_o  out  1  at least one ProbeAckData received
busy_o  out  1  state != IDLE
err_o  out  1  one-cycle pulse on unexpected ack

Behaviour:
- Reset (async, rst_n=0): state IDLE; issue/ack masks 0; dirty 0; req_ready_o=1; b_valid_o=0; done_valid_o=0; busy_o=0; err_o=0; b_dest_o=0; latched fields 0. Reset mid-operation abandons the probe, no completion reported.
- Registers: pend_issue[N] (targets not yet sent), issued[N] (sent, ack outstanding), dirty.
- IDLE: req_ready_o=1. On req fire: latch fields; pend_issue<=req_targets_i; issued<=0; dirty<=0. Nonzero targets -> ISSUE; zero targets -> DONE (no B beats).
- ISSUE: b_valid_o=1; b_dest_o = index of lowest set bit of pend_issue (registered; valid from cycle after accept, i.e. first B beat at cycle 1). b_* fields stable while b_valid_o && !b_ready_i. On B fire: clear that bit in pend_issue, set it in issued, b_dest_o advances next cycle; no idle cycle between beats under continuous b_ready_i. Last fire -> WAIT (or DONE if all acks already returned).
- Acks accepted in ISSUE and WAIT (no ready; always sunk). Valid ack: issued[ack_client_i] set (pre-update value) -> clear bit; dirty |= ack_data_i. Otherwise (client never probed, already acked, or state IDLE/DONE): no state change, err_o=1 next cycle.
- Ack and B fire in same cycle for different clients: both applied. Ack for client whose beat fires that same cycle counts as unexpected.
- WAIT: when issued==0 and pend_issue==0 -> DONE.
- DONE: done_valid_o=1, done_dirty_o=dirty, held until done_ready_i; on fire -> IDLE. req_ready_o=0 outside IDLE.
- Total cycles, K targets, no backpressure, acks immediate: accept(0), beats 1..K, done_valid_o no later than cycle K+2 after last ack.

Test Plan:
- Single target: targets=4'b0100, param=2, addr=0x1000 -> one B beat at cycle 1, dest=2, opcode=6, mask=FF; ack client 2 data=0 -> done_valid_o, done_dirty_o=0.
- All targets with b_ready_i low 3 cycles on beat 2 -> beats dest 0,1,2,3 in order, fields stable during stall; acks in order 3,1,0,2 with client 1 data=1 -> done_dirty_o=1.
- targets=0 -> no B beat, done_valid_o cycle 1, dirty 0; done_ready_i low 5 cycles -> held, req_ready_o=0 throughout.
- Ack from client 3 when targets=4'b0011 and duplicate ack from client 0 -> err_o pulse each, completion unaffected.
- Ack of client 0 same cycle as B fire to client 1 (targets=4'b0011) -> both applied, no err, done after client 1 ack.
- Assert rst_n mid-ISSUE -> b_valid_o, busy_o drop immediately; next command processes cleanly.
